// File: rtl/vga_timing_pkg.sv
// Shared types, display mode presets and sizing helpers for the VGA raster
// timing generator and its axis counters.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FP,
        REGION_SYNC,
        REGION_BP
    } axis_region_e;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    // Mode presets: 640x480@60, 800x600@60 and a reduced 320x240 bring-up mode.
    localparam axis_timing_t MODE_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t MODE_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam axis_timing_t MODE_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam axis_timing_t MODE_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};
    localparam axis_timing_t MODE_320X240_H = '{active: 320, fp: 8,  sync: 48,  bp: 24};
    localparam axis_timing_t MODE_320X240_V = '{active: 240, fp: 3,  sync: 4,   bp: 15};

    function automatic int axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int count_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

    function automatic axis_region_e axis_region(input int pos, input axis_timing_t t);
        if (pos < t.active)
            return REGION_ACTIVE;
        if (pos < t.active + t.fp)
            return REGION_FP;
        if (pos < t.active + t.fp + t.sync)
            return REGION_SYNC;
        return REGION_BP;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable input and raster outputs of the timing generator, bundled for
// the sprite/colour logic that consumes them.
interface vga_timing_gen_if #(
    parameter int XW  = 10,
    parameter int YW  = 10,
    parameter int FCW = 16
);

    logic           i_pix_en;
    logic           o_hs;
    logic           o_vs;
    logic           o_active;
    logic           o_blanking;
    logic           o_line_start;
    logic           o_frame_start;
    logic           o_animate;
    logic [XW-1:0]  o_x;
    logic [YW-1:0]  o_y;
    logic [FCW-1:0] o_frame_cnt;

    modport master (
        output i_pix_en,
        input  o_hs, o_vs, o_active, o_blanking,
        input  o_line_start, o_frame_start, o_animate,
        input  o_x, o_y, o_frame_cnt
    );

    modport slave (
        input  i_pix_en,
        output o_hs, o_vs, o_active, o_blanking,
        output o_line_start, o_frame_start, o_animate,
        output o_x, o_y, o_frame_cnt
    );

endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter with enable, plus decode of the
// value it will hold after this edge so the parent can register it zero-skew.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    localparam axis_timing_t TIMING = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP},
    localparam int TOTAL = axis_total(TIMING),
    localparam int W     = count_width(TOTAL)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt_next,
    output logic         o_at_last,
    output logic         o_active_next,
    output logic         o_sync_next
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    axis_region_e region_d;

    // Parked on the last position so the first enable after reset lands on 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= LAST;
        else
            cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_en)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign region_d      = axis_region(int'(cnt_d), TIMING);
    assign o_cnt_next    = cnt_d;
    assign o_at_last     = (cnt_q == LAST);
    assign o_active_next = (region_d == REGION_ACTIVE);
    assign o_sync_next   = (region_d == REGION_SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: chained H/V axis counters with
// registered decode, line/frame/animate strobes and a wrapping frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int FCW      = 16
) (
    input logic            i_clk,
    input logic            i_rst_n,
    vga_timing_gen_if.slave bus
);

    localparam axis_timing_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_timing_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int H_TOTAL = axis_total(H_TIMING);
    localparam int V_TOTAL = axis_total(V_TIMING);
    localparam int XW      = count_width(H_TOTAL);
    localparam int YW      = count_width(V_TOTAL);

    localparam logic [YW-1:0] Y_HOLD = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_ANIM = YW'(V_ACTIVE);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FCW < 1) begin : g_param_check
        $error("vga_timing_gen: every timing parameter and FCW must be >= 1");
    end

    logic [XW-1:0] h_next;
    logic          h_last;
    logic          h_active_next;
    logic          h_sync_next;
    logic [YW-1:0] v_next;
    logic          v_last;
    logic          v_active_next;
    logic          v_sync_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (bus.i_pix_en),
        .o_cnt_next    (h_next),
        .o_at_last     (h_last),
        .o_active_next (h_active_next),
        .o_sync_next   (h_sync_next)
    );

    // The vertical axis only steps on the pixel that wraps the line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (bus.i_pix_en & h_last),
        .o_cnt_next    (v_next),
        .o_at_last     (v_last),
        .o_active_next (v_active_next),
        .o_sync_next   (v_sync_next)
    );

    logic           hs_q;
    logic           vs_q;
    logic           active_q;
    logic           blanking_q;
    logic           line_start_q;
    logic           frame_start_q;
    logic           animate_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic [FCW-1:0] frame_cnt_q;

    // Level outputs follow the counters' next value on the same edge; strobes
    // self-clear every clock so they stay one cycle wide whatever i_pix_en does.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            active_q      <= 1'b0;
            blanking_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            animate_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= Y_HOLD;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            animate_q     <= 1'b0;
            if (bus.i_pix_en) begin
                hs_q          <= h_sync_next;
                vs_q          <= v_sync_next;
                active_q      <= h_active_next & v_active_next;
                blanking_q    <= ~(h_active_next & v_active_next);
                x_q           <= h_active_next ? h_next : '0;
                y_q           <= v_active_next ? v_next : Y_HOLD;
                line_start_q  <= h_last;
                frame_start_q <= h_last & v_last;
                animate_q     <= h_last & (v_next == Y_ANIM);
                if (h_last && v_last)
                    frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_hs          = hs_q;
    assign bus.o_vs          = vs_q;
    assign bus.o_active      = active_q;
    assign bus.o_blanking    = blanking_q;
    assign bus.o_line_start  = line_start_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_animate     = animate_q;
    assign bus.o_x           = x_q;
    assign bus.o_y           = y_q;
    assign bus.o_frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the display path, replacing the fixed 640x480 generator. It generalises horizontal and vertical timing, sync polarity and pixel rate through a pixel-enable strobe. It adds asynchronous active-low reset, registered glitch-free outputs, line/frame/animate strobes and a frame counter. It sits between the pixel clock domain and the sprite/colour logic, which consumes `o_x`, `o_y`, `o_active` and the strobes.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 0: active level of `o_hs` (0 = active-low).
- `VS_POL`, 0: active level of `o_vs`.
- `FCW`, 16: frame counter width.
- Derived: `H_TOTAL` = sum of H terms; `V_TOTAL` = sum of V terms; `XW` = clog2(H_TOTAL); `YW` = clog2(V_TOTAL).
- `i_clk`  in  1  system/pixel clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_pix_en`  in  1  pixel strobe; counters advance only in cycles where it is 1. Tie to 1 for one pixel per clock.
- `o_hs`  out  1  horizontal sync, polarity `HS_POL`.
- `o_vs`  out  1  vertical sync, polarity `VS_POL`.
- `o_active`  out  1  current pixel is visible.
- `o_blanking`  out  1  always the inverse of `o_active`.
- `o_line_start`  out  1  one-cycle strobe on entering h=0.
- `o_frame_start`  out  1  one-cycle strobe on entering (0,0).
- `o_animate`  out  1  one-cycle strobe on entering (0,V_ACTIVE), i.e. the first vblank line.
- `o_x`  out  XW  pixel x position.
- `o_y`  out  YW  pixel y position.
- `o_frame_cnt`  out  FCW  number of frames started, wrapping.

## Operation
- Line order is active, FP, sync, BP. Frame order is the same.
- `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. On that wrap, `v_cnt` increments, and wraps 0 after V_TOTAL-1.
- `o_hs` is at active level iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). `o_vs` uses the same rule with V terms.
- `o_active` = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- `o_x` = h_cnt when h_cnt < H_ACTIVE, else 0.
- `o_y` = v_cnt when v_cnt < V_ACTIVE, else V_ACTIVE-1. This holds y stable through vblank for game logic.
- `o_frame_cnt` increments in the same cycle `o_frame_start` asserts. It wraps from 2^FCW-1 to 0.
- All outputs are flops, with no combinational path from inputs to outputs.
- Elaboration check: every timing parameter ≥ 1, and FCW ≥ 1.

## Timing
- Reset state (async assert, sync to `i_clk` on release):
  - counters at (H_TOTAL-1, V_TOTAL-1);
  - `o_hs` = ~HS_POL, `o_vs` = ~VS_POL;
  - `o_active` = 0, `o_blanking` = 1;
  - strobes = 0;
  - `o_x` = 0, `o_y` = V_ACTIVE-1;
  - `o_frame_cnt` = 0.
- The first `i_pix_en` after reset enters (0,0). That cycle raises `o_frame_start` and `o_line_start`, sets `o_active` = 1, and sets `o_frame_cnt` = 1.
- Decoded outputs are computed from the next counter value and registered on the same edge as the counters. They are therefore zero-skew with the counter, with one-clock latency from `i_pix_en`.
- Strobes are high for exactly one `i_clk` cycle, following the advancing edge. They clear on the next clock even if `i_pix_en` = 0.
- When `i_pix_en` = 0, counters and level outputs hold.
- Reset mid-frame immediately forces the reset state. The next frame restarts cleanly from (0,0).
- On the last pixel of the frame, the h wrap and v wrap happen on the same edge. `o_line_start` and `o_frame_start` assert together.

## Structure
- Package `vga_timing_pkg` holds:
  - localparam sets for the 640x480@60, 800x600@60 and 320x240 test modes;
  - a helper function for total and width calculation.
- Sub-module `vga_axis_counter`, parameters ACTIVE/FP/SYNC/BP/POL, instantiated once for H and once for V:
  - wrapping counter with enable;
  - next-value decode of active, sync and wrap.
- The top level chains the two instances, drives the strobes and the frame counter, and registers the outputs.

## Test plan
- Defaults, `i_pix_en` = 1, two frames → `o_hs` active-low for 96 clocks starting at h=656, with 800-clock line period. `o_vs` low for 2 lines starting at v=490, with 525-line frame period. `o_frame_cnt` = 2.
- Small mode (H 4/1/2/1, V 3/1/1/1, HS_POL = VS_POL = 1) → line is 8 clocks, `o_hs` high at h=5..6. Frame is 48 clocks, `o_vs` high on line 4. `o_animate` fires at clock 24 after the frame start.
- `i_pix_en` toggling every other clock, small mode → all periods doubled. Each strobe stays exactly 1 clock wide.
- Assert `i_rst_n` = 0 mid-line at h=300, v=100 → all outputs take reset values within the same cycle. After release, the first `i_pix_en` gives `o_frame_start` = 1 with `o_x` = 0, `o_y` = 0, `o_frame_cnt` = 1.
- FCW = 2, run 5 frames → `o_frame_cnt` sequence 1,2,3,0,1.
- Last pixel (799,524) → next edge gives `o_line_start` = `o_frame_start` = 1 in the same cycle. `o_y` holds at 479 throughout vblank.
